// File: rtl/qpmm_iter.sv
// Digit-serial Montgomery multiplier: Z = A*B*2^(-K*N) mod M, one K-bit digit of B per clock,
// with valid/ready handshakes on both sides and a final conditional subtraction.
module qpmm_iter #(
  parameter int K = 17,
  parameter int N = 16,
  parameter logic [K*N-1:0] MODULUS =
    272'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter logic [K-1:0] MPRIME = 17'h06389
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K*N-1:0] in_a,
  input  logic [K*N-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K*N-1:0] out_z
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready=1
  // MUL   | one digit of B folded into T per clock, N clocks
  // CORR  | single conditional subtraction of M, result registered
  // DONE  | result presented until the consumer takes it

  localparam int W  = K * N;
  localparam int UW = W + K + 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W+1:0]  t_reg;
  logic [CW-1:0] cnt;

  logic [UW-1:0] u;
  logic [UW-1:0] v;
  logic [K-1:0]  q;
  logic [W+1:0]  t_next;
  logic [W+1:0]  t_corr;
  logic [K-1:0]  unused_v_lsb;
  logic [1:0]    unused_t_corr_msb;

  // b_reg shifts right each iteration, so its low digit is always the current b_i.
  always_comb begin
    u      = UW'(t_reg) + UW'(a_reg) * UW'(b_reg[K-1:0]);
    q      = u[K-1:0] * MPRIME;
    v      = u + UW'(MODULUS) * UW'(q);
    t_next = v[UW-1:K];
  end

  assign unused_v_lsb = v[K-1:0];

  always_comb begin
    if (t_reg >= {2'b00, MODULUS})
      t_corr = t_reg - {2'b00, MODULUS};
    else
      t_corr = t_reg;
  end

  assign unused_t_corr_msb = t_corr[W+1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_z     <= '0;
      cnt       <= '0;
      t_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            t_reg    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          t_reg <= t_next;
          b_reg <= b_reg >> K;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1))
            state <= CORR;
        end
        CORR: begin
          out_z     <= t_corr[W-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpmm_iter.sv
// Bench for qpmm_iter: a small K=4/N=2/M=181 instance for directed boundary cases and the
// default BN254 instance for random operands, both against an A*B*R^-1 mod M reference.
module tb_qpmm_iter;

  localparam logic [271:0] P =
    272'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small configuration
  logic       sm_rst, sm_in_valid, sm_in_ready, sm_out_valid, sm_out_ready;
  logic [7:0] sm_in_a, sm_in_b, sm_out_z;

  // default BN254 configuration
  logic         bn_rst, bn_in_valid, bn_in_ready, bn_out_valid, bn_out_ready;
  logic [271:0] bn_in_a, bn_in_b, bn_out_z;

  int errors = 0;
  int checks = 0;
  int sm_rinv;
  logic [543:0] bn_rinv;

  qpmm_iter #(.K(4), .N(2), .MODULUS(8'd181), .MPRIME(4'd3)) dut_sm (
    .clk(clk), .rst(sm_rst),
    .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_a(sm_in_a), .in_b(sm_in_b),
    .out_valid(sm_out_valid), .out_ready(sm_out_ready), .out_z(sm_out_z)
  );

  qpmm_iter dut_bn (
    .clk(clk), .rst(bn_rst),
    .in_valid(bn_in_valid), .in_ready(bn_in_ready), .in_a(bn_in_a), .in_b(bn_in_b),
    .out_valid(bn_out_valid), .out_ready(bn_out_ready), .out_z(bn_out_z)
  );

  task automatic chk(input string tag, input logic [271:0] got, input logic [271:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One small-config product; 'hold' cycles of back-pressure with in_valid pulses in DONE.
  task automatic sm_run(input int a, input int b, input int hold);
    int lat;
    int exp;
    exp = (a * b * sm_rinv) % 181;
    chk("sm_ready_before", sm_in_ready, 1);
    sm_in_a = 8'(a);
    sm_in_b = 8'(b);
    sm_in_valid = 1'b1;
    sm_out_ready = 1'b0;
    tick();
    sm_in_valid = 1'b0;
    chk("sm_busy", sm_in_ready, 0);
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (sm_out_valid) break;
    end
    chk("sm_latency", lat, 3);
    chk("sm_z", sm_out_z, exp);
    for (int i = 0; i < hold; i++) begin
      sm_in_valid = 1'b1;
      sm_in_a = 8'($urandom_range(0, 180));
      sm_in_b = 8'($urandom_range(0, 180));
      tick();
      sm_in_valid = 1'b0;
      chk("sm_hold_valid", sm_out_valid, 1);
      chk("sm_hold_z", sm_out_z, exp);
      chk("sm_hold_ready", sm_in_ready, 0);
    end
    sm_out_ready = 1'b1;
    tick();
    sm_out_ready = 1'b0;
    chk("sm_hs_valid", sm_out_valid, 0);
    chk("sm_hs_ready", sm_in_ready, 1);
    chk("sm_z_kept", sm_out_z, exp);
  endtask

  task automatic bn_rand(output logic [271:0] x);
    logic [287:0] r;
    logic [287:0] m;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    m = r % {16'b0, P};
    x = m[271:0];
  endtask

  function automatic logic [271:0] bn_model(input logic [271:0] a, input logic [271:0] b);
    logic [543:0] ab;
    logic [543:0] z;
    ab = ({272'b0, a} * {272'b0, b}) % {272'b0, P};
    z = (ab * bn_rinv) % {272'b0, P};
    return z[271:0];
  endfunction

  task automatic bn_run(input logic [271:0] a, input logic [271:0] b);
    int lat;
    logic [271:0] exp;
    logic r;
    bit done;
    exp = bn_model(a, b);
    chk("bn_ready_before", bn_in_ready, 1);
    bn_in_a = a;
    bn_in_b = b;
    bn_in_valid = 1'b1;
    tick();
    bn_in_valid = 1'b0;
    lat = 0;
    while (lat < 60) begin
      bn_out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (bn_out_valid) break;
    end
    chk("bn_latency", lat, 17);
    chk("bn_z", bn_out_z, exp);
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      r = 1'($urandom_range(0, 1));
      bn_out_ready = r;
      tick();
      if (r) done = 1'b1;
      else chk("bn_hold_z", bn_out_z, exp);
    end
    if (!done) begin
      chk("bn_hs_timeout", 0, 1);
      bn_out_ready = 1'b1;
      tick();
    end
    bn_out_ready = 1'b0;
    chk("bn_hs_valid", bn_out_valid, 0);
    chk("bn_hs_ready", bn_in_ready, 1);
  endtask

  initial begin
    logic [271:0] a;
    logic [271:0] b;
    logic [271:0] x;
    bit seen;

    // R^-1 for both configurations, from the definition of a modular inverse
    sm_rinv = 0;
    for (int i = 1; i < 181; i++) if ((256 * i) % 181 == 1) sm_rinv = i;
    x = 272'd1;
    for (int i = 0; i < 272; i++) begin
      if (x[0]) x = 272'(({1'b0, x} + {1'b0, P}) >> 1);
      else x = x >> 1;
    end
    bn_rinv = {272'b0, x};

    sm_rst = 1'b1; bn_rst = 1'b1;
    sm_in_valid = 1'b0; sm_out_ready = 1'b0; sm_in_a = '0; sm_in_b = '0;
    bn_in_valid = 1'b0; bn_out_ready = 1'b0; bn_in_a = '0; bn_in_b = '0;
    tick();
    tick();
    sm_rst = 1'b0; bn_rst = 1'b0;
    chk("sm_rst_ready", sm_in_ready, 1);
    chk("sm_rst_valid", sm_out_valid, 0);
    chk("sm_rst_z", sm_out_z, 0);
    chk("bn_rst_ready", bn_in_ready, 1);
    chk("bn_rst_valid", bn_out_valid, 0);
    chk("bn_rst_z", bn_out_z, 0);

    // out_ready with nothing to deliver is ignored
    sm_out_ready = 1'b1;
    tick();
    sm_out_ready = 1'b0;
    chk("sm_idle_ready", sm_in_ready, 1);
    chk("sm_idle_valid", sm_out_valid, 0);

    sm_run(1, 75, 0);
    sm_run(180, 180, 0);
    sm_run(75, 75, 0);
    sm_run(0, 123, 0);
    sm_run(123, 0, 0);
    sm_run(100, 37, 5);

    // reset on the edge after acceptance discards the operation
    sm_in_a = 8'd180; sm_in_b = 8'd180; sm_in_valid = 1'b1;
    tick();
    sm_in_valid = 1'b0;
    sm_rst = 1'b1;
    tick();
    sm_rst = 1'b0;
    chk("sm_mid_rst_ready", sm_in_ready, 1);
    chk("sm_mid_rst_valid", sm_out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sm_out_valid) seen = 1'b1;
    end
    chk("sm_mid_rst_no_result", seen, 0);
    sm_run(1, 75, 0);

    for (int i = 0; i < 40; i++)
      sm_run(int'($urandom_range(0, 180)), int'($urandom_range(0, 180)), int'($urandom_range(0, 2)));

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        bn_out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      bn_rand(a);
      bn_rand(b);
      if (n == 0) a = '0;
      if (n == 1) begin a = P - 272'd1; b = P - 272'd1; end
      bn_run(a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
